// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder: AXI-Stream to SHA-256 register-interface initiator.
// Each accepted word is presented on string_o/ctrl_signals_o with the strobe
// (ctrl[31]) held high for HOLD_CYCLES, then low for HOLD_CYCLES. After the
// last word the feeder waits for finish_repeat_i, captures the digest and
// pulses hash_valid_o for one cycle.
// Optional build macro SHA_FEEDER_BYTESWAP_EN: byte-swap tdata and bit-reverse
// tkeep for little-endian host buffers.
module sha256_msg_feeder #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CORE_W         = 3
) (
  input  logic              axi_clk_i,
  input  logic              areset_i,
  input  logic [31:0]       s_tdata,
  input  logic [3:0]        s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [CORE_W-1:0] core_sel_i,
  input  logic [19:0]       repeat_cfg_i,
  output logic [31:0]       ctrl_signals_o,
  output logic [31:0]       string_o,
  output logic [31:0]       repeat_o,
  input  logic              finish_repeat_i,
  input  logic [255:0]      hash_i,
  output logic [255:0]      hash_o,
  output logic              hash_valid_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StAssert, StDeassert, StWaitHash, StDone} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [ToW-1:0]   to_cnt_q;
  logic             seen_clear_q;
  logic             strobe_q;
  logic             last_q;
  logic [3:0]       keep_q;
  logic [3:0]       core_q;
  logic [31:0]      string_q;
  logic [19:0]      repeat_q;
  logic [255:0]     hash_q;
  logic             hash_valid_q;
  logic             busy_q;
  logic             timeout_err_q;

  logic [31:0]      word_in;
  logic [3:0]       keep_in;

`ifdef SHA_FEEDER_BYTESWAP_EN
  assign word_in = {s_tdata[7:0], s_tdata[15:8], s_tdata[23:16], s_tdata[31:24]};
  assign keep_in = {s_tkeep[0], s_tkeep[1], s_tkeep[2], s_tkeep[3]};
`else
  assign word_in = s_tdata;
  assign keep_in = s_tkeep;
`endif

  // Ready only in IDLE; forced low while reset is asserted.
  assign s_tready       = (state_q == StIdle) && !areset_i;
  assign ctrl_signals_o = {strobe_q, last_q, 22'b0, core_q, keep_q};
  assign string_o       = string_q;
  assign repeat_o       = {12'b0, repeat_q};
  assign hash_o         = hash_q;
  assign hash_valid_o   = hash_valid_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = timeout_err_q;

  // Handshake FSM with all outputs registered.
  always_ff @(posedge axi_clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
      seen_clear_q  <= 1'b0;
      strobe_q      <= 1'b0;
      last_q        <= 1'b0;
      keep_q        <= '0;
      core_q        <= '0;
      string_q      <= '0;
      repeat_q      <= '0;
      hash_q        <= '0;
      hash_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      hash_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_tvalid) begin
            string_q   <= word_in;
            keep_q     <= keep_in;
            last_q     <= s_tlast;
            strobe_q   <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StAssert;
            // First word of a message: latch job configuration.
            if (!busy_q) begin
              core_q        <= 4'(core_sel_i);
              repeat_q      <= repeat_cfg_i;
              busy_q        <= 1'b1;
              timeout_err_q <= 1'b0;
              seen_clear_q  <= 1'b0;
            end
          end
        end
        StAssert: begin
          if (hold_cnt_q == HoldMax) begin
            strobe_q   <= 1'b0;
            hold_cnt_q <= '0;
            state_q    <= StDeassert;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StDeassert: begin
          if (hold_cnt_q == HoldMax) begin
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            state_q    <= last_q ? StWaitHash : StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StWaitHash: begin
          // A finish flag counts only after it has been seen low in this job.
          if (!finish_repeat_i) seen_clear_q <= 1'b1;
          if (seen_clear_q && finish_repeat_i) begin
            hash_q       <= hash_i;
            hash_valid_q <= 1'b1;
            state_q      <= StDone;
          end else if (to_cnt_q == ToMax) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed self-checking bench for sha256_msg_feeder (HOLD 16, timeout 64).
module tb_sha256_msg_feeder;

  localparam int unsigned Hold = 16;
  localparam int unsigned To   = 64;
  localparam int unsigned Cw   = 3;

  localparam logic [255:0] HashAbc =
    256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
  localparam logic [255:0] HashB = 256'h0123456789ABCDEF_FEDCBA9876543210_55AA55AA55AA55AA_0F0F0F0F0F0F0F0F;
  localparam logic [255:0] HashC = 256'hCAFEBABE_00000001_DEADBEEF_00000002_12345678_00000003_87654321_00000004;

  logic          axi_clk_i = 1'b0;
  logic          areset_i = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic [3:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [Cw-1:0] core_sel_i = '0;
  logic [19:0]   repeat_cfg_i = '0;
  logic [31:0]   ctrl_signals_o;
  logic [31:0]   string_o;
  logic [31:0]   repeat_o;
  logic          finish_repeat_i = 1'b0;
  logic [255:0]  hash_i = '0;
  logic [255:0]  hash_o;
  logic          hash_valid_o;
  logic          busy_o;
  logic          timeout_err_o;

  int n_cmp = 0;
  int n_err = 0;

  sha256_msg_feeder #(
    .HOLD_CYCLES   (Hold),
    .TIMEOUT_CYCLES(To),
    .CORE_W        (Cw)
  ) dut (
    .axi_clk_i      (axi_clk_i),
    .areset_i       (areset_i),
    .s_tdata        (s_tdata),
    .s_tkeep        (s_tkeep),
    .s_tlast        (s_tlast),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .core_sel_i     (core_sel_i),
    .repeat_cfg_i   (repeat_cfg_i),
    .ctrl_signals_o (ctrl_signals_o),
    .string_o       (string_o),
    .repeat_o       (repeat_o),
    .finish_repeat_i(finish_repeat_i),
    .hash_i         (hash_i),
    .hash_o         (hash_o),
    .hash_valid_o   (hash_valid_o),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o)
  );

  always #5 axi_clk_i = ~axi_clk_i;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef SHA_FEEDER_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] exp_keep(input logic [3:0] k);
`ifdef SHA_FEEDER_BYTESWAP_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  function automatic logic [31:0] exp_ctrl(input logic stb, input logic lst,
                                           input logic [3:0] core, input logic [3:0] k);
    return {stb, lst, 22'b0, core, exp_keep(k)};
  endfunction

  task automatic tick();
    @(posedge axi_clk_i);
    #1;
  endtask

  // Present one word and return 1ns after the accepting edge.
  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    while (!s_tready && n < 100) begin
      tick();
      n++;
    end
    check_eq("tready_wait", s_tready, 1'b1);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  // One word through its full strobe-high / strobe-low window.
  task automatic word_phases(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [3:0] core);
    push(d, k, l);
    check_eq("ctrl_strobe_start", ctrl_signals_o, exp_ctrl(1'b1, l, core, k));
    check_eq("string", string_o, exp_word(d));
    check_eq("tready_low_start", s_tready, 1'b0);
    repeat (Hold - 1) tick();
    check_eq("ctrl_strobe_end", ctrl_signals_o, exp_ctrl(1'b1, l, core, k));
    tick();
    check_eq("ctrl_strobe_low", ctrl_signals_o, exp_ctrl(1'b0, l, core, k));
    repeat (Hold - 1) tick();
    check_eq("tready_low_end", s_tready, 1'b0);
    tick();
    // Non-last words return to IDLE after 2*Hold cycles; last word waits for the hash.
    check_eq("tready_after_word", s_tready, !l);
  endtask

  // Accelerator model: finish low for two cycles, then high with the digest.
  task automatic finish_job(input logic [255:0] h);
    finish_repeat_i = 1'b0;
    repeat (2) tick();
    hash_i          = h;
    finish_repeat_i = 1'b1;
    tick();
    check_eq("hash_valid_pulse", hash_valid_o, 1'b1);
    check_eq("hash_value", hash_o, h);
    tick();
    check_eq("hash_valid_drop", hash_valid_o, 1'b0);
    check_eq("busy_after_done", busy_o, 1'b0);
    finish_repeat_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Reset state
    #1 areset_i = 1'b1;
    #2;
    check_eq("rst_ctrl", ctrl_signals_o, 32'h0);
    check_eq("rst_string", string_o, 32'h0);
    check_eq("rst_repeat", repeat_o, 32'h0);
    check_eq("rst_hash", hash_o, 256'h0);
    check_eq("rst_flags", {hash_valid_o, busy_o, timeout_err_o, s_tready}, 4'b0000);
    repeat (2) tick();
    areset_i = 1'b0;
    tick();
    check_eq("idle_tready", s_tready, 1'b1);

    // Single-word "abc"
    core_sel_i   = 3'd0;
    repeat_cfg_i = 20'd0;
    word_phases(32'h61626300, 4'hE, 1'b1, 4'd0);
    check_eq("abc_busy", busy_o, 1'b1);
    finish_job(HashAbc);

    // Two-word message, core 5; config changes mid-message are ignored
    core_sel_i   = 3'd5;
    repeat_cfg_i = 20'hABCDE;
    word_phases(32'h11223344, 4'hF, 1'b0, 4'd5);
    check_eq("w1_ctrl_abs", ctrl_signals_o, exp_ctrl(1'b0, 1'b0, 4'd5, 4'hF));
    check_eq("w1_repeat", repeat_o, 32'h000ABCDE);
    core_sel_i   = 3'd2;
    repeat_cfg_i = 20'h12345;
    finish_repeat_i = 1'b1;  // toggling during the handshake has no effect
    word_phases(32'h55667788, 4'hF, 1'b1, 4'd5);
    check_eq("w2_repeat", repeat_o, 32'h000ABCDE);
    finish_job(HashB);

    // Stale finish flag held high through the job
    core_sel_i      = 3'd1;
    repeat_cfg_i    = 20'd7;
    finish_repeat_i = 1'b1;
    word_phases(32'hA5A5A5A5, 4'hC, 1'b1, 4'd1);
    cnt = 0;
    repeat (5) begin
      tick();
      if (hash_valid_o) cnt++;
    end
    check_eq("stale_no_valid", cnt, 0);
    check_eq("stale_busy", busy_o, 1'b1);
    finish_repeat_i = 1'b0;
    repeat (2) tick();
    hash_i          = HashC;
    finish_repeat_i = 1'b1;
    cnt = 0;
    repeat (4) begin
      tick();
      if (hash_valid_o) cnt++;
    end
    check_eq("stale_one_valid", cnt, 1);
    check_eq("stale_hash", hash_o, HashC);
    finish_repeat_i = 1'b0;

    // Timeout: finish never returns; keep=0 forwarded unchanged
    core_sel_i = 3'd0;
    word_phases(32'hDEADBEEF, 4'h0, 1'b1, 4'd0);
    check_eq("keep_zero_ctrl", ctrl_signals_o[3:0], exp_keep(4'h0));
    cnt = 0;
    repeat (To - 1) begin
      tick();
      if (hash_valid_o) cnt++;
    end
    check_eq("to_not_yet", {timeout_err_o, busy_o}, 2'b01);
    tick();
    if (hash_valid_o) cnt++;
    check_eq("to_fired", {timeout_err_o, busy_o}, 2'b10);
    check_eq("to_no_valid", cnt, 0);
    repeat (3) tick();
    check_eq("to_sticky", timeout_err_o, 1'b1);
    word_phases(32'h61626300, 4'hE, 1'b1, 4'd0);
    check_eq("to_cleared", timeout_err_o, 1'b0);
    finish_job(HashAbc);

    // Reset asserted mid-ASSERT
    core_sel_i   = 3'd6;
    repeat_cfg_i = 20'hFFFFF;
    push(32'h01020304, 4'hF, 1'b0);
    repeat (5) tick();
    areset_i = 1'b1;
    #1;
    check_eq("mid_rst_ctrl", ctrl_signals_o, 32'h0);
    check_eq("mid_rst_data", {string_o, repeat_o}, 64'h0);
    check_eq("mid_rst_flags", {hash_valid_o, busy_o, timeout_err_o, s_tready}, 4'b0000);
    tick();
    areset_i = 1'b0;
    cnt = 0;
    repeat (3) begin
      tick();
      if (hash_valid_o) cnt++;
    end
    check_eq("mid_rst_no_valid", cnt, 0);
    check_eq("mid_rst_tready", s_tready, 1'b1);
    core_sel_i   = 3'd0;
    repeat_cfg_i = 20'd0;
    word_phases(32'h61626300, 4'hE, 1'b1, 4'd0);
    finish_job(HashAbc);

`ifdef SHA_FEEDER_BYTESWAP_EN
    // Little-endian host word
    word_phases(32'h00636261, 4'h7, 1'b1, 4'd0);
    check_eq("bswap_string", string_o, 32'h61626300);
    check_eq("bswap_keep", ctrl_signals_o[3:0], 4'hE);
    finish_job(HashAbc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
